// File: rtl/decode_execute_core_if.sv
// ----------------------------------------------------------------------------
// decode_execute_core_if
//   Bundles every non-clock/reset signal of decode_execute_core.
//   Handshake: i_insn_vld qualifies i_inst/i_pc for the cycle it is high.
//   There is no ready signal. The only backpressure is i_stall, which turns
//   the ID/EX load into a bubble while the upstream stage holds its word.
//   o_insn_vld_mem qualifies the EX/MEM outputs in the same way.
//
//   Modports
//     master : fetch/writeback/hazard side (drives i_*, observes o_*)
//     slave  : the decode/execute core (observes i_*, drives o_*)
//
//   Signals
//     i_inst, i_pc, i_insn_vld        IF/ID word, PC and valid
//     i_stall                         load-use bubble request
//     i_rd_addr, i_rd_data, i_rd_wren writeback port
//     i_fwd_operand_a/b               forward selects for rs1/rs2
//     o_rs1_addr, o_rs2_addr          decode-stage source registers
//     o_inst_ex, o_wb_sel_ex,
//     o_rd_wren_ex                    ID/EX view for hazard/forward units
//     o_alu_data ... o_ctrl_mem       EX/MEM register contents
//     o_pc_sel, o_flush               branch redirect and pipeline flush
// ----------------------------------------------------------------------------
interface decode_execute_core_if;
   logic [31:0] i_inst;
   logic [31:0] i_pc;
   logic        i_insn_vld;
   logic        i_stall;
   logic [4:0]  i_rd_addr;
   logic [31:0] i_rd_data;
   logic        i_rd_wren;
   logic [1:0]  i_fwd_operand_a;
   logic [1:0]  i_fwd_operand_b;

   logic [4:0]  o_rs1_addr;
   logic [4:0]  o_rs2_addr;
   logic [31:0] o_inst_ex;
   logic [1:0]  o_wb_sel_ex;
   logic        o_rd_wren_ex;
   logic [31:0] o_alu_data;
   logic        o_br_equal;
   logic        o_br_less;
   logic [31:0] o_pc_mem;
   logic [31:0] o_rs2_data_mem;
   logic [31:0] o_inst_mem;
   logic        o_lsu_wren_mem;
   logic [2:0]  o_slt_sl_mem;
   logic [1:0]  o_wb_sel_mem;
   logic        o_rd_wren_mem;
   logic        o_insn_vld_mem;
   logic        o_ctrl_mem;
   logic        o_pc_sel;
   logic        o_flush;

   modport master (
      output i_inst, i_pc, i_insn_vld, i_stall, i_rd_addr, i_rd_data,
             i_rd_wren, i_fwd_operand_a, i_fwd_operand_b,
      input  o_rs1_addr, o_rs2_addr, o_inst_ex, o_wb_sel_ex, o_rd_wren_ex,
             o_alu_data, o_br_equal, o_br_less, o_pc_mem, o_rs2_data_mem,
             o_inst_mem, o_lsu_wren_mem, o_slt_sl_mem, o_wb_sel_mem,
             o_rd_wren_mem, o_insn_vld_mem, o_ctrl_mem, o_pc_sel, o_flush
   );

   modport slave (
      input  i_inst, i_pc, i_insn_vld, i_stall, i_rd_addr, i_rd_data,
             i_rd_wren, i_fwd_operand_a, i_fwd_operand_b,
      output o_rs1_addr, o_rs2_addr, o_inst_ex, o_wb_sel_ex, o_rd_wren_ex,
             o_alu_data, o_br_equal, o_br_less, o_pc_mem, o_rs2_data_mem,
             o_inst_mem, o_lsu_wren_mem, o_slt_sl_mem, o_wb_sel_mem,
             o_rd_wren_mem, o_insn_vld_mem, o_ctrl_mem, o_pc_sel, o_flush
   );
endinterface

// File: rtl/decode_execute_core.sv
// ----------------------------------------------------------------------------
// decode_execute_core
//   RV32I decode + execute + branch resolution. Holds the 32x32 register
//   file, immediate generator, control decoder, ID/EX register, forwarding
//   muxes, ALU, branch comparator and EX/MEM register.
//
//   Ports
//     i_clk    rising-edge clock
//     i_reset  synchronous active-high reset (register file not cleared)
//     bus      decode_execute_core_if.slave, all datapath/control signals
//
//   Configuration macro
//     REGFILE_BYPASS_EN  when defined, a register read whose address matches
//                        an active writeback (nonzero address) returns the
//                        writeback data in the same cycle.
// ----------------------------------------------------------------------------
module decode_execute_core #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   decode_execute_core_if.slave  bus
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        asel;      // 1: operand A is PC
      logic        bsel;      // 1: operand B is immediate
      logic [1:0]  wb_sel;
      logic        rd_wren;
      logic        lsu_wren;
      logic        br_un;
      logic        ctrl;
      logic        insn_vld;
   } idex_t;

   typedef struct packed {
      logic [31:0] alu_data;
      logic        br_equal;
      logic        br_less;
      logic [31:0] pc;
      logic [31:0] rs2_data;
      logic [31:0] inst;
      logic        lsu_wren;
      logic [2:0]  slt_sl;
      logic [1:0]  wb_sel;
      logic        rd_wren;
      logic        insn_vld;
      logic        ctrl;
   } exmem_t;

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [31:0] rf_q [32];
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_rd, rs2_rd;

   always_ff @(posedge i_clk) begin
      if (bus.i_rd_wren && (bus.i_rd_addr != 5'd0))
         rf_q[bus.i_rd_addr] <= bus.i_rd_data;
   end

   assign rs1_addr = bus.i_inst[19:15];
   assign rs2_addr = bus.i_inst[24:20];

   always_comb begin
      rs1_rd = '0;
      rs2_rd = '0;
      if (rs1_addr != 5'd0) rs1_rd = rf_q[rs1_addr];
      if (rs2_addr != 5'd0) rs2_rd = rf_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.i_rd_wren && (bus.i_rd_addr != 5'd0) && (bus.i_rd_addr == rs1_addr))
         rs1_rd = bus.i_rd_data;
      if (bus.i_rd_wren && (bus.i_rd_addr != 5'd0) && (bus.i_rd_addr == rs2_addr))
         rs2_rd = bus.i_rd_data;
`else
      // Same-cycle writes become visible on the following cycle only.
`endif
   end

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        legal;
   logic        dec_vld;
   idex_t       idex_d, idex_q, idex_bubble;

   assign inst   = bus.i_inst;
   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      legal = 1'b0;
      idex_d          = '0;
      idex_d.inst     = inst;
      idex_d.pc       = bus.i_pc;
      idex_d.rs1_data = rs1_rd;
      idex_d.rs2_data = rs2_rd;
      idex_d.imm      = imm_i;
      idex_d.alu_op   = ALU_ADD;
      idex_d.bsel     = 1'b1;
      idex_d.wb_sel   = 2'b01;

      case (opcode)
         OP_LUI: begin
            legal = 1'b1;
            idex_d.imm     = imm_u;
            idex_d.alu_op  = ALU_PASSB;
            idex_d.rd_wren = 1'b1;
         end
         OP_AUIPC: begin
            legal = 1'b1;
            idex_d.imm     = imm_u;
            idex_d.asel    = 1'b1;
            idex_d.rd_wren = 1'b1;
         end
         OP_JAL: begin
            legal = 1'b1;
            idex_d.imm     = imm_j;
            idex_d.asel    = 1'b1;
            idex_d.wb_sel  = 2'b00;
            idex_d.rd_wren = 1'b1;
            idex_d.ctrl    = 1'b1;
         end
         OP_JALR: begin
            legal = 1'b1;
            idex_d.wb_sel  = 2'b00;
            idex_d.rd_wren = 1'b1;
            idex_d.ctrl    = 1'b1;
         end
         OP_BRANCH: begin
            legal = 1'b1;
            idex_d.imm   = imm_b;
            idex_d.asel  = 1'b1;
            idex_d.br_un = (funct3 == 3'b110) || (funct3 == 3'b111);
            idex_d.ctrl  = 1'b1;
         end
         OP_LOAD: begin
            legal = 1'b1;
            idex_d.wb_sel  = 2'b10;
            idex_d.rd_wren = 1'b1;
         end
         OP_STORE: begin
            legal = 1'b1;
            idex_d.imm      = imm_s;
            idex_d.lsu_wren = 1'b1;
         end
         OP_IMM, OP_REG: begin
            legal = 1'b1;
            idex_d.rd_wren = 1'b1;
            idex_d.bsel    = (opcode == OP_IMM);
            case (funct3)
               // SUB exists only in R-type; ADDI never subtracts.
               3'b000:  idex_d.alu_op = (opcode == OP_REG && inst[30]) ? ALU_SUB : ALU_ADD;
               3'b001:  idex_d.alu_op = ALU_SLL;
               3'b010:  idex_d.alu_op = ALU_SLT;
               3'b011:  idex_d.alu_op = ALU_SLTU;
               3'b100:  idex_d.alu_op = ALU_XOR;
               3'b101:  idex_d.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
               3'b110:  idex_d.alu_op = ALU_OR;
               default: idex_d.alu_op = ALU_AND;
            endcase
         end
         default: legal = 1'b0;
      endcase

      // Invalid or illegal words travel down the pipe with every enable low.
      dec_vld          = bus.i_insn_vld && legal;
      idex_d.insn_vld  = dec_vld;
      idex_d.rd_wren   = idex_d.rd_wren  && dec_vld;
      idex_d.lsu_wren  = idex_d.lsu_wren && dec_vld;
      idex_d.ctrl      = idex_d.ctrl     && dec_vld;
   end

   always_comb begin
      idex_bubble      = '0;
      idex_bubble.inst = NOP_INST;
   end

   // ------------------------------------------------------------------
   // ID/EX register
   // ------------------------------------------------------------------
   logic pc_sel;

   always_ff @(posedge i_clk) begin
      if (i_reset || pc_sel || bus.i_stall)
         idex_q <= idex_bubble;
      else
         idex_q <= idex_d;
   end

   // ------------------------------------------------------------------
   // Execute
   // ------------------------------------------------------------------
   exmem_t      exmem_d, exmem_q, exmem_bubble;
   logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
   logic [4:0]  shamt;

   always_comb begin
      case (bus.i_fwd_operand_a)
         2'b01:   fwd_a = exmem_q.alu_data;
         2'b10:   fwd_a = bus.i_rd_data;
         default: fwd_a = idex_q.rs1_data;
      endcase
      case (bus.i_fwd_operand_b)
         2'b01:   fwd_b = exmem_q.alu_data;
         2'b10:   fwd_b = bus.i_rd_data;
         default: fwd_b = idex_q.rs2_data;
      endcase
   end

   assign op_a  = idex_q.asel ? idex_q.pc  : fwd_a;
   assign op_b  = idex_q.bsel ? idex_q.imm : fwd_b;
   assign shamt = op_b[4:0];

   always_comb begin
      case (idex_q.alu_op)
         ALU_ADD:   alu_res = op_a + op_b;
         ALU_SUB:   alu_res = op_a - op_b;
         ALU_SLL:   alu_res = op_a << shamt;
         ALU_SLT:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:  alu_res = {31'b0, op_a < op_b};
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_SRL:   alu_res = op_a >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:    alu_res = op_a | op_b;
         ALU_AND:   alu_res = op_a & op_b;
         ALU_PASSB: alu_res = op_b;
         default:   alu_res = '0;
      endcase
      if (idex_q.inst[6:0] == OP_JALR)
         alu_res = {alu_res[31:1], 1'b0};
   end

   always_comb begin
      exmem_d          = '0;
      exmem_d.alu_data = alu_res;
      exmem_d.br_equal = (fwd_a == fwd_b);
      exmem_d.br_less  = idex_q.br_un ? (fwd_a < fwd_b)
                                      : ($signed(fwd_a) < $signed(fwd_b));
      exmem_d.pc       = idex_q.pc;
      exmem_d.rs2_data = fwd_b;
      exmem_d.inst     = idex_q.inst;
      exmem_d.lsu_wren = idex_q.lsu_wren;
      exmem_d.slt_sl   = idex_q.inst[14:12];
      exmem_d.wb_sel   = idex_q.wb_sel;
      exmem_d.rd_wren  = idex_q.rd_wren;
      exmem_d.insn_vld = idex_q.insn_vld;
      exmem_d.ctrl     = idex_q.ctrl;
   end

   always_comb begin
      exmem_bubble      = '0;
      exmem_bubble.inst = NOP_INST;
   end

   // ------------------------------------------------------------------
   // EX/MEM register: a redirect kills the wrong-path word now in EX.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset || pc_sel)
         exmem_q <= exmem_bubble;
      else
         exmem_q <= exmem_d;
   end

   // ------------------------------------------------------------------
   // Branch resolution from EX/MEM
   // ------------------------------------------------------------------
   always_comb begin
      pc_sel = 1'b0;
      if (exmem_q.insn_vld) begin
         case (exmem_q.inst[6:0])
            OP_JAL, OP_JALR: pc_sel = 1'b1;
            OP_BRANCH: begin
               case (exmem_q.inst[14:12])
                  3'b000:         pc_sel =  exmem_q.br_equal;
                  3'b001:         pc_sel = !exmem_q.br_equal;
                  3'b100, 3'b110: pc_sel =  exmem_q.br_less;
                  3'b101, 3'b111: pc_sel = !exmem_q.br_less;
                  default:        pc_sel = 1'b0;
               endcase
            end
            default: pc_sel = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.o_rs1_addr     = rs1_addr;
   assign bus.o_rs2_addr     = rs2_addr;
   assign bus.o_inst_ex      = idex_q.inst;
   assign bus.o_wb_sel_ex    = idex_q.wb_sel;
   assign bus.o_rd_wren_ex   = idex_q.rd_wren;
   assign bus.o_alu_data     = exmem_q.alu_data;
   assign bus.o_br_equal     = exmem_q.br_equal;
   assign bus.o_br_less      = exmem_q.br_less;
   assign bus.o_pc_mem       = exmem_q.pc;
   assign bus.o_rs2_data_mem = exmem_q.rs2_data;
   assign bus.o_inst_mem     = exmem_q.inst;
   assign bus.o_lsu_wren_mem = exmem_q.lsu_wren;
   assign bus.o_slt_sl_mem   = exmem_q.slt_sl;
   assign bus.o_wb_sel_mem   = exmem_q.wb_sel;
   assign bus.o_rd_wren_mem  = exmem_q.rd_wren;
   assign bus.o_insn_vld_mem = exmem_q.insn_vld;
   assign bus.o_ctrl_mem     = exmem_q.ctrl;
   assign bus.o_pc_sel       = pc_sel;
   assign bus.o_flush        = pc_sel;

endmodule

// File: tb/tb_decode_execute_core.sv
module tb_decode_execute_core;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic i_clk;
   logic i_reset;
   int   n_vec;
   int   n_err;

   decode_execute_core_if bus ();

   decode_execute_core #(.NOP_INST(NOP)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // driver tasks
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_inst(input logic [31:0] inst, input logic [31:0] pc);
      bus.i_inst     = inst;
      bus.i_pc       = pc;
      bus.i_insn_vld = 1'b1;
   endtask

   task automatic filler();
      bus.i_inst     = NOP;
      bus.i_pc       = 32'h0;
      bus.i_insn_vld = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one word, let it reach EX/MEM (two edges), leave it visible.
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
      drive_inst(inst, pc);
      tick();
      filler();
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      i_reset             = 1'b0;
      bus.i_stall         = 1'b0;
      bus.i_rd_addr       = 5'd0;
      bus.i_rd_data       = 32'h0;
      bus.i_rd_wren       = 1'b0;
      bus.i_fwd_operand_a = 2'b00;
      bus.i_fwd_operand_b = 2'b00;
      filler();

      // reset
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      chk("rst_inst_mem", bus.o_inst_mem, NOP);
      chk("rst_rd_wren_mem", {31'b0, bus.o_rd_wren_mem}, 32'd0);
      chk("rst_pc_sel", {31'b0, bus.o_pc_sel}, 32'd0);
      chk("rst_flush", {31'b0, bus.o_flush}, 32'd0);
      chk("rst_inst_ex", bus.o_inst_ex, NOP);

      // x1 = 5 through writeback port
      bus.i_rd_wren = 1'b1;
      bus.i_rd_addr = 5'd1;
      bus.i_rd_data = 32'd5;
      tick();
      bus.i_rd_wren = 1'b0;
      bus.i_rd_data = 32'd0;

      // ADDI x2,x1,7
      drive_inst(32'h0070_8113, 32'h0);
      #1;
      chk("addi_rs1_addr", {27'b0, bus.o_rs1_addr}, 32'd1);
      chk("addi_rs2_addr", {27'b0, bus.o_rs2_addr}, 32'd7);
      tick();
      chk("addi_inst_ex", bus.o_inst_ex, 32'h0070_8113);
      chk("addi_wb_sel_ex", {30'b0, bus.o_wb_sel_ex}, 32'd1);
      chk("addi_rd_wren_ex", {31'b0, bus.o_rd_wren_ex}, 32'd1);
      filler();
      tick();
      chk("addi_alu", bus.o_alu_data, 32'd12);
      chk("addi_wb_sel", {30'b0, bus.o_wb_sel_mem}, 32'd1);
      chk("addi_rd_wren", {31'b0, bus.o_rd_wren_mem}, 32'd1);
      chk("addi_inst_mem", bus.o_inst_mem, 32'h0070_8113);
      chk("addi_pc_sel", {31'b0, bus.o_pc_sel}, 32'd0);
      tick();

      // SW x1,4(x0)
      issue(32'h0010_2223, 32'h0);
      chk("sw_alu", bus.o_alu_data, 32'd4);
      chk("sw_lsu_wren", {31'b0, bus.o_lsu_wren_mem}, 32'd1);
      chk("sw_rd_wren", {31'b0, bus.o_rd_wren_mem}, 32'd0);
      chk("sw_store_data", bus.o_rs2_data_mem, 32'd5);
      chk("sw_funct3", {29'b0, bus.o_slt_sl_mem}, 32'd2);
      tick();

      // LUI x5,0x12345
      issue(32'h1234_52B7, 32'h0);
      chk("lui_alu", bus.o_alu_data, 32'h1234_5000);
      tick();

      // BEQ x0,x0,+8 at 0x100
      issue(32'h0000_0463, 32'h0000_0100);
      chk("beq_alu", bus.o_alu_data, 32'h0000_0108);
      chk("beq_equal", {31'b0, bus.o_br_equal}, 32'd1);
      chk("beq_pc_sel", {31'b0, bus.o_pc_sel}, 32'd1);
      chk("beq_flush", {31'b0, bus.o_flush}, 32'd1);
      chk("beq_ctrl", {31'b0, bus.o_ctrl_mem}, 32'd1);
      chk("beq_pc_mem", bus.o_pc_mem, 32'h0000_0100);
      tick();
      chk("beq_next_inst", bus.o_inst_mem, NOP);
      chk("beq_next_rd_wren", {31'b0, bus.o_rd_wren_mem}, 32'd0);
      chk("beq_next_pc_sel", {31'b0, bus.o_pc_sel}, 32'd0);

      // JAL x1,+0x40 at 0x20
      issue(32'h0400_00EF, 32'h0000_0020);
      chk("jal_alu", bus.o_alu_data, 32'h0000_0060);
      chk("jal_pc_sel", {31'b0, bus.o_pc_sel}, 32'd1);
      chk("jal_wb_sel", {30'b0, bus.o_wb_sel_mem}, 32'd0);
      chk("jal_ctrl", {31'b0, bus.o_ctrl_mem}, 32'd1);
      chk("jal_rd_wren", {31'b0, bus.o_rd_wren_mem}, 32'd1);
      tick();

      // SLTU x3,x1,x0 with rs1 forwarded from i_rd_data = -1
      drive_inst(32'h0000_B1B3, 32'h0);
      tick();
      filler();
      bus.i_fwd_operand_a = 2'b10;
      bus.i_rd_data       = 32'hFFFF_FFFF;
      tick();
      bus.i_fwd_operand_a = 2'b00;
      chk("sltu_fwd_alu", bus.o_alu_data, 32'd0);
      tick();

      // SLT x3,x1,x0 same forwarding
      drive_inst(32'h0000_A1B3, 32'h0);
      tick();
      filler();
      bus.i_fwd_operand_a = 2'b10;
      tick();
      bus.i_fwd_operand_a = 2'b00;
      chk("slt_fwd_alu", bus.o_alu_data, 32'd1);
      tick();

      // BLT x1,x0,+8 at 0x200, signed -1 < 0 -> taken
      drive_inst(32'h0000_C463, 32'h0000_0200);
      tick();
      filler();
      bus.i_fwd_operand_a = 2'b10;
      tick();
      bus.i_fwd_operand_a = 2'b00;
      chk("blt_alu", bus.o_alu_data, 32'h0000_0208);
      chk("blt_less", {31'b0, bus.o_br_less}, 32'd1);
      chk("blt_pc_sel", {31'b0, bus.o_pc_sel}, 32'd1);
      tick();

      // BLTU x1,x0,+8, unsigned 0xFFFFFFFF < 0 false -> not taken
      drive_inst(32'h0000_E463, 32'h0000_0200);
      tick();
      filler();
      bus.i_fwd_operand_a = 2'b10;
      tick();
      bus.i_fwd_operand_a = 2'b00;
      bus.i_rd_data       = 32'h0;
      chk("bltu_less", {31'b0, bus.o_br_less}, 32'd0);
      chk("bltu_pc_sel", {31'b0, bus.o_pc_sel}, 32'd0);
      tick();

      // Stall one cycle on ADDI x2,x1,7 held upstream
      bus.i_stall = 1'b1;
      drive_inst(32'h0070_8113, 32'h0);
      tick();
      bus.i_stall = 1'b0;
      chk("stall_inst_ex", bus.o_inst_ex, NOP);
      tick();
      chk("stall_bubble_inst", bus.o_inst_mem, NOP);
      chk("stall_bubble_wren", {31'b0, bus.o_rd_wren_mem}, 32'd0);
      filler();
      tick();
      chk("stall_done_inst", bus.o_inst_mem, 32'h0070_8113);
      chk("stall_done_alu", bus.o_alu_data, 32'd12);
      tick();

      // Write 0x55 to x0, then ADDI x4,x0,0 reads 0
      bus.i_rd_wren = 1'b1;
      bus.i_rd_addr = 5'd0;
      bus.i_rd_data = 32'h55;
      tick();
      bus.i_rd_wren = 1'b0;
      bus.i_rd_data = 32'h0;
      issue(32'h0000_0213, 32'h0);
      chk("x0_read", bus.o_alu_data, 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
